// File: rtl/eda_pixel_loader.sv
// Raster-stream to image-RAM loader for eda_regional_max: writes one M x N frame, pulses start, waits for done.
// Optional EDA_LOADER_LAST_CHECK_EN: validate s_last against the frame geometry and flag framing errors.
module eda_pixel_loader #(
    parameter int M           = 8,
    parameter int N           = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int I_WIDTH     = 3,
    parameter int J_WIDTH     = 3,
    parameter int ADDR_WIDTH  = I_WIDTH + J_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PIXEL_WIDTH-1:0] s_pixel,
    input  logic                   s_last,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   write_en,
    output logic                   start,
    input  logic                   done,
    output logic                   busy,
    output logic [15:0]            frame_cnt,
    output logic                   frame_err
);

    // Handshake: a pixel transfers on a rising edge where s_valid && s_ready.
    // s_ready is registered from state alone and is high only while loading.
    typedef enum logic [1:0] {IDLE, LOAD, START, BUSY} state_t;

    state_t             state;
    logic [I_WIDTH-1:0] i;
    logic [J_WIDTH-1:0] j;
    logic               last_pix;
    logic               accept;

    assign last_pix = (i == I_WIDTH'(M - 1)) && (j == J_WIDTH'(N - 1));
    assign accept   = s_valid && s_ready;

`ifndef EDA_LOADER_LAST_CHECK_EN
    logic unused_s_last;
    assign unused_s_last = s_last;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            s_ready   <= 1'b0;
            wr_addr   <= '0;
            pixel_out <= '0;
            write_en  <= 1'b0;
            start     <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
            frame_err <= 1'b0;
        end else begin
            write_en <= 1'b0;
            start    <= 1'b0;
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    state   <= LOAD;
                end
                LOAD: begin
                    if (accept) begin
                        write_en  <= 1'b1;
                        wr_addr   <= {i, j};
                        pixel_out <= s_pixel;
                        if (last_pix) begin
                            i       <= '0;
                            j       <= '0;
                            s_ready <= 1'b0;
                            state   <= START;
`ifdef EDA_LOADER_LAST_CHECK_EN
                            if (!s_last) frame_err <= 1'b1;
`endif
                        end
`ifdef EDA_LOADER_LAST_CHECK_EN
                        // Early s_last truncates the frame; the core is never started on it.
                        else if (s_last) begin
                            frame_err <= 1'b1;
                            i         <= '0;
                            j         <= '0;
                            s_ready   <= 1'b0;
                            state     <= IDLE;
                        end
`endif
                        else if (j == J_WIDTH'(N - 1)) begin
                            j <= '0;
                            i <= i + 1'b1;
                        end else begin
                            j <= j + 1'b1;
                        end
                    end
                end
                START: begin
                    start <= 1'b1;
                    busy  <= 1'b1;
                    state <= BUSY;
                end
                BUSY: begin
                    // Leaving through IDLE keeps a held done from counting twice.
                    if (done) begin
                        busy      <= 1'b0;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eda_pixel_loader.sv
// Randomised bench for eda_pixel_loader: frame-level reference model plus literal pins on key timings.
// Build with +define+EDA_LOADER_LAST_CHECK_EN to include the framing-error scenario.
module tb_eda_pixel_loader;
    localparam int M  = 8;
    localparam int N  = 8;
    localparam int PW = 8;
    localparam int IW = 3;
    localparam int JW = 3;
    localparam int AW = IW + JW;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, s_last;
    logic [PW-1:0] s_pixel, pixel_out;
    logic [AW-1:0] wr_addr;
    logic          write_en, start, done, busy, frame_err;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    eda_pixel_loader #(.M(M), .N(N), .PIXEL_WIDTH(PW), .I_WIDTH(IW), .J_WIDTH(JW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(rst), .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
        .s_last(s_last), .wr_addr(wr_addr), .pixel_out(pixel_out), .write_en(write_en),
        .start(start), .done(done), .busy(busy), .frame_cnt(frame_cnt), .frame_err(frame_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame-level view of the loader, updated on each rising edge.
    logic [AW+PW-1:0] exp_q[$];
    bit        m_ready, m_we, m_start, m_busy, m_err, pend_start;
    int        ready_delay, idx;
    logic [15:0] m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready = 0; m_we = 0; m_start = 0; m_busy = 0; m_err = 0;
            pend_start = 0; ready_delay = 1; idx = 0; m_cnt = '0;
            exp_q.delete();
        end else begin
            m_we = 0;
            m_start = 0;
            if (pend_start) begin
                pend_start = 0; m_start = 1; m_busy = 1;
            end else if (m_busy) begin
                if (done) begin m_busy = 0; m_cnt = m_cnt + 16'd1; ready_delay = 1; end
            end else if (ready_delay > 0) begin
                ready_delay--;
                if (ready_delay == 0) m_ready = 1;
            end else if (m_ready && s_valid) begin
                m_we = 1;
                exp_q.push_back({AW'(((idx / N) << JW) | (idx % N)), s_pixel});
                idx++;
                if (idx == M * N) begin
                    idx = 0; m_ready = 0; pend_start = 1;
`ifdef EDA_LOADER_LAST_CHECK_EN
                    if (!s_last) m_err = 1;
`endif
                end
`ifdef EDA_LOADER_LAST_CHECK_EN
                else if (s_last) begin
                    m_err = 1; idx = 0; m_ready = 0; ready_delay = 1;
                end
`endif
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    int cyc = 0, we_cnt = 0, start_cnt = 0, last_we_cyc = 0, start_cyc = 0;
    logic [AW+PW-1:0] e;

    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            chk("s_ready", s_ready, m_ready);
            chk("write_en", write_en, m_we);
            chk("start", start, m_start);
            chk("busy", busy, m_busy);
            chk("frame_cnt", frame_cnt, m_cnt);
            chk("frame_err", frame_err, m_err);
            if (write_en) begin
                chk("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", wr_addr, e[AW+PW-1:PW]);
                    chk("pixel_out", pixel_out, e[PW-1:0]);
                end
                we_cnt++;
                last_we_cyc = cyc;
            end
            if (start) begin
                start_cnt++;
                start_cyc = cyc;
            end
        end
    end

    // mode 0: continuous valid, 1: toggling valid, 2: random valid
    task automatic send_pixels(input int count, input int mode, input int last_at, input bit rnd);
        int k = 0;
        int guard = 0;
        bit v;
        while (k < count && guard < 1000) begin
            @(negedge clk);
            guard++;
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 1;
                default: v = 1'($urandom_range(0, 1));
            endcase
            s_valid = v;
            s_pixel = rnd ? PW'($urandom) : PW'(k);
            s_last  = (k == last_at);
            if (v && s_ready) k++;
        end
        if (k < count) chk("send_timeout", k, count);
    endtask

    task automatic wait_start();
        int s0 = start_cnt;
        int g = 0;
        while (start_cnt == s0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("start_seen", start_cnt - s0, 1);
    endtask

    task automatic do_done(input int hold);
        repeat (2) @(negedge clk);
        done = 1'b1;
        repeat (hold) @(negedge clk);
        done = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_write_en", write_en, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_pixel_out", pixel_out, 0);
        #1 rst = 1'b0;
    endtask

    int we0, s0;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_pixel = '0; s_last = 1'b0; done = 1'b0;
        apply_reset();

        // Frame 1: continuous stream, pixel value = index, valid held after the frame.
        we0 = we_cnt; s0 = start_cnt;
        send_pixels(M * N, 0, M * N - 1, 0);
        wait_start();
        chk("f1_writes", we_cnt - we0, 64);
        chk("f1_starts", start_cnt - s0, 1);
        chk("f1_start_lat", start_cyc - last_we_cyc, 1);
        repeat (20) @(negedge clk);
        chk("f1_hold_ready", s_ready, 0);
        chk("f1_hold_busy", busy, 1);
        done = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        done = 1'b0;
        chk("f1_cnt", frame_cnt, 1);
        chk("f1_busy_clr", busy, 0);
        @(negedge clk);
        chk("f1_ready_back", s_ready, 1);

        // Frame 2: toggling valid, random pixels.
        we0 = we_cnt; s0 = start_cnt;
        send_pixels(M * N, 1, M * N - 1, 1);
        @(negedge clk); s_valid = 1'b0;
        wait_start();
        chk("f2_writes", we_cnt - we0, 64);
        chk("f2_start_lat", start_cyc - last_we_cyc, 1);
        do_done(1);

        // Reset mid-frame after 30 pixels, then a full random frame.
        send_pixels(30, 2, -1, 1);
        @(negedge clk); s_valid = 1'b0;
        s0 = start_cnt;
        apply_reset();
        repeat (10) @(negedge clk);
        chk("mid_no_start", start_cnt - s0, 0);
        send_pixels(M * N, 2, M * N - 1, 1);
        @(negedge clk); s_valid = 1'b0;
        wait_start();
        chk("mid_cnt", frame_cnt, 0);
        do_done(1);

`ifdef EDA_LOADER_LAST_CHECK_EN
        // Early s_last on pixel 10 truncates; following good frame starts normally.
        s0 = start_cnt;
        send_pixels(11, 2, 10, 1);
        @(negedge clk); s_valid = 1'b0; s_last = 1'b0;
        repeat (5) @(negedge clk);
        chk("trunc_err", frame_err, 1);
        chk("trunc_no_start", start_cnt - s0, 0);
        send_pixels(M * N, 2, M * N - 1, 1);
        @(negedge clk); s_valid = 1'b0; s_last = 1'b0;
        wait_start();
        chk("trunc_err_sticky", frame_err, 1);
        do_done(1);
`endif

        // Back-to-back frames with done held high for 5 cycles each time.
        apply_reset();
        send_pixels(M * N, 2, M * N - 1, 1);
        @(negedge clk); s_valid = 1'b0;
        wait_start();
        fork
            begin
                done = 1'b1;
                repeat (5) @(negedge clk);
                done = 1'b0;
            end
            send_pixels(M * N, 2, M * N - 1, 1);
        join
        @(negedge clk); s_valid = 1'b0;
        wait_start();
        chk("b2b_start_lat", start_cyc - last_we_cyc, 1);
        done = 1'b1;
        repeat (5) @(negedge clk);
        done = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_cnt", frame_cnt, 2);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eda_pixel_loader.md
Name: eda_pixel_loader

Overview:
- Upstream feeder for eda_regional_max.
- Accepts a raster-order pixel stream over a valid/ready handshake and converts it into the core's image-RAM write port (wr_addr = {i,j}, pixel_in, write_en).
- After the last pixel of an M x N frame is written, issues a single-cycle start pulse, then holds off the stream until the core asserts done.
- Sequences back-to-back frames without software intervention.

Parameters:
- M, 8, image rows.
- N, 8, image columns.
- PIXEL_WIDTH, 8, pixel bit width.
- I_WIDTH, 3, row index width; must satisfy 2^I_WIDTH >= M.
- J_WIDTH, 3, column index width; must satisfy 2^J_WIDTH >= N.
- ADDR_WIDTH, I_WIDTH+J_WIDTH, core RAM address width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  stream pixel valid.
- s_ready  out  1  loader can accept a pixel.
- s_pixel  in  PIXEL_WIDTH  stream pixel, raster order (row-major).
- s_last  in  1  marks the final pixel of a frame; used only with the optional feature.
- wr_addr  out  ADDR_WIDTH  core RAM write address {i,j}.
- pixel_out  out  PIXEL_WIDTH  core RAM write data; connects to core pixel_in.
- write_en  out  1  core RAM write strobe.
- start  out  1  one-cycle start pulse to core.
- done  in  1  core completion, level-sensitive.
- busy  out  1  frame handed to core and not yet done.
- frame_cnt  out  16  frames completed (done observed), wraps at 2^16.
- frame_err  out  1  sticky framing error; optional feature only, else tied 0.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, i=0, j=0.
- Output reset values: s_ready=0, wr_addr=0, pixel_out=0, write_en=0, start=0, busy=0, frame_cnt=0, frame_err=0.
- States and transitions:
  - IDLE: s_ready=0 → LOAD next cycle.
  - LOAD: s_ready=1. Accept when s_valid&s_ready at a rising edge. On accept, register wr_addr={i,j}, pixel_out=s_pixel, write_en=1 for exactly one cycle. Advance j; when j==N-1, set j=0 and i=i+1.
  - LOAD, on accepting pixel (M-1,N-1): clear i,j to 0, state → START.
  - START: s_ready=0. Registered start=1 for exactly one cycle; this is the cycle after the final write_en. Then → BUSY.
  - BUSY: s_ready=0, busy=1. When done==1, frame_cnt+=1, busy=0, state → IDLE.
  - IDLE exit: IDLE always lasts one cycle, so a done held high cannot retrigger.
- Address is the concatenation {i,j}, not i*N+j. Addresses with j>=N or i>=M are never generated.
- Latency: accept edge → write_en/wr_addr/pixel_out valid in the following cycle. Final accept → start asserted 2 cycles later (write_en, then start).
- write_en stays 0 on cycles with no accept; gaps in s_valid are allowed.
- s_ready is a registered function of state only; it does not depend combinationally on s_valid.
- done asserted outside BUSY is ignored.
- Reset mid-frame: partial frame discarded, counters cleared, no start issued. Core RAM contents are not cleared.

Optional Feature:
- Macro: EDA_LOADER_LAST_CHECK_EN.
- Defined:
  - s_last is compared on every accept.
  - s_last=1 before pixel (M-1,N-1): frame_err set (sticky until reset). The frame is truncated: i,j cleared, state → IDLE, no start.
  - s_last=0 on pixel (M-1,N-1): frame_err set; start still issued normally.
- Not defined: s_last is ignored and frame_err is constant 0.

Test Plan:
- Reset then a continuous stream of M*N=64 pixels, value = index: 64 write_en pulses; wr_addr sequence 0x00,0x01..0x07,0x08..0x3F; pixel_out equals index; start one cycle after the 64th write_en; s_ready=0 afterwards.
- s_valid toggled 1/0 every cycle (mirrors the bench's write_en gaps): same address/data sequence with write_en only on accepted cycles; start still exactly once.
- After start, hold s_valid=1 and assert done 20 cycles later: s_ready stays 0 and busy=1 throughout; done → frame_cnt=1, busy=0; s_ready=1 two cycles after done.
- Assert reset after 30 pixels, release, then send a full frame: no start before the new frame; addresses restart at 0x00; frame_cnt=0.
- With EDA_LOADER_LAST_CHECK_EN, s_last=1 on pixel 10: frame_err=1, no start; next full frame with correct s_last gives a normal start and frame_err remains 1.
- Two back-to-back frames with done held high for 5 cycles: frame_cnt=2 (not 6); second start follows the second frame's 64th write.
